// File: rtl/k423_if_ibuf.sv
// k423_if_ibuf: IF-to-ID instruction buffer with outstanding-request PC tracking,
// credit-based fetch throttling and stale-response dropping after a clear.
`ifndef CORE_ADDR_W
`define CORE_ADDR_W 32
`endif
`ifndef CORE_DATA_W
`define CORE_DATA_W 32
`endif
`ifndef CORE_FETCH_W
`define CORE_FETCH_W `CORE_DATA_W
`endif

module k423_if_ibuf #(
   parameter int IBUF_DEPTH = 4,
   parameter int OST_DEPTH  = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     pcu_clear_if_i,
   input  logic                     if_mem_req_vld_i,
   input  logic                     if_mem_req_rdy_i,
   input  logic [`CORE_ADDR_W-1:0]  if_mem_req_addr_i,
   input  logic                     if_mem_rsp_vld_i,
   input  logic [`CORE_FETCH_W-1:0] if_mem_rsp_rdata_i,
   output logic                     fetch_credit_o,
   output logic                     if_stage_vld_o,
   input  logic                     id_stage_rdy_i,
   output logic [`CORE_ADDR_W-1:0]  pc_o,
   output logic [`CORE_DATA_W-1:0]  inst_o,
   output logic                     rsp_unexp_o
);
   localparam int AW  = `CORE_ADDR_W;
   localparam int DW  = `CORE_DATA_W;
   localparam int IPW = $clog2(IBUF_DEPTH);
   localparam int OPW = (OST_DEPTH > 1) ? $clog2(OST_DEPTH) : 1;
   localparam int ICW = IPW + 1;
   localparam int OCW = $clog2(OST_DEPTH) + 1;
   localparam int SW  = ICW + 1;
   localparam bit OWRAP = (OST_DEPTH > 1);

   logic [AW-1:0]  pcq_q [OST_DEPTH];
   logic [AW-1:0]  pcq_d [OST_DEPTH];
   logic [AW-1:0]  ipc_q [IBUF_DEPTH];
   logic [AW-1:0]  ipc_d [IBUF_DEPTH];
   logic [DW-1:0]  iins_q [IBUF_DEPTH];
   logic [DW-1:0]  iins_d [IBUF_DEPTH];
   logic [OPW-1:0] pwr_q, pwr_d, prd_q, prd_d;
   logic [IPW-1:0] iwr_q, iwr_d, ird_q, ird_d;
   logic [OCW-1:0] ost_cnt_q, ost_cnt_d, drop_cnt_q, drop_cnt_d;
   logic [ICW-1:0] ibuf_cnt_q, ibuf_cnt_d;
   logic           unexp_q, unexp_d;
   logic           req_acc, rsp_acc, rsp_bad, drop, push, pop;

   assign fetch_credit_o = (ost_cnt_q < OCW'(OST_DEPTH)) &&
                           (SW'(ost_cnt_q) + SW'(ibuf_cnt_q) < SW'(IBUF_DEPTH));
   assign req_acc        = if_mem_req_vld_i & if_mem_req_rdy_i & fetch_credit_o;
   assign rsp_bad        = if_mem_rsp_vld_i & (ost_cnt_q == '0);
   assign rsp_acc        = if_mem_rsp_vld_i & (ost_cnt_q != '0);
   assign drop           = rsp_acc & (pcu_clear_if_i | (drop_cnt_q != '0));
   assign push           = rsp_acc & ~drop;
   assign if_stage_vld_o = (ibuf_cnt_q != '0);
   assign pop            = if_stage_vld_o & id_stage_rdy_i;
   assign pc_o           = ipc_q[ird_q];
   assign inst_o         = iins_q[ird_q];
   assign rsp_unexp_o    = unexp_q;

   always_comb begin
      pcq_d = pcq_q;
      if (req_acc) pcq_d[pwr_q] = if_mem_req_addr_i;
      pwr_d = pwr_q + OPW'(req_acc & OWRAP);
      prd_d = prd_q + OPW'(rsp_acc & OWRAP);
      ost_cnt_d = ost_cnt_q + OCW'(req_acc) - OCW'(rsp_acc);
      // a clear condemns everything still in flight after this cycle, which
      // already includes any earlier condemned beats, so it replaces drop_cnt
      drop_cnt_d = pcu_clear_if_i ? ost_cnt_q - OCW'(rsp_acc)
                                  : drop_cnt_q - OCW'(rsp_acc & (drop_cnt_q != '0));
      ipc_d  = ipc_q;
      iins_d = iins_q;
      if (push) begin
         ipc_d[iwr_q]  = pcq_q[prd_q];
         iins_d[iwr_q] = if_mem_rsp_rdata_i;
      end
      iwr_d      = iwr_q + IPW'(push);
      ird_d      = pcu_clear_if_i ? iwr_q : ird_q + IPW'(pop);
      ibuf_cnt_d = pcu_clear_if_i ? '0 : ibuf_cnt_q + ICW'(push) - ICW'(pop);
      unexp_d    = unexp_q | rsp_bad;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pcq_q      <= '{default: '0};
         ipc_q      <= '{default: '0};
         iins_q     <= '{default: '0};
         pwr_q      <= '0;
         prd_q      <= '0;
         iwr_q      <= '0;
         ird_q      <= '0;
         ost_cnt_q  <= '0;
         drop_cnt_q <= '0;
         ibuf_cnt_q <= '0;
         unexp_q    <= 1'b0;
      end else begin
         pcq_q      <= pcq_d;
         ipc_q      <= ipc_d;
         iins_q     <= iins_d;
         pwr_q      <= pwr_d;
         prd_q      <= prd_d;
         iwr_q      <= iwr_d;
         ird_q      <= ird_d;
         ost_cnt_q  <= ost_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         ibuf_cnt_q <= ibuf_cnt_d;
         unexp_q    <= unexp_d;
      end
   end
endmodule
